// File: rtl/lsu_ctrl.sv
// Load/store unit control: turns an ALU-computed effective address and rs2
// into one req/gnt/rvalid transaction on the data bus, then returns the
// sign/zero-extended load result to writeback. One op in flight at a time.
module lsu_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic               is_load,
  input  logic               is_store,
  input  logic [2:0]         funct3,
  input  logic [D_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] wdata,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [3:0]         mem_be,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [D_WIDTH-1:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  // funct3 encodings for access size and signedness
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [TO_W-1:0] cnt;
  logic            is_load_q;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;

  // Decode of the op presented in IDLE
  logic               fault;
  logic [3:0]         acc_be;
  logic [D_WIDTH-1:0] acc_wdata;

  // Shift the addressed lane down to bit 0 and extend it to a full word.
  function automatic logic [D_WIDTH-1:0] load_ext(
    input logic [D_WIDTH-1:0] word,
    input logic [1:0]         off,
    input logic [2:0]         f3
  );
    logic [D_WIDTH-1:0] s;
    logic [D_WIDTH-1:0] r;
    s = word >> {off, 3'b000};
    case (f3)
      F3_B:    r = {{(D_WIDTH-8){s[7]}}, s[7:0]};
      F3_BU:   r = {{(D_WIDTH-8){1'b0}}, s[7:0]};
      F3_H:    r = {{(D_WIDTH-16){s[15]}}, s[15:0]};
      F3_HU:   r = {{(D_WIDTH-16){1'b0}}, s[15:0]};
      default: r = word;
    endcase
    return r;
  endfunction

  // Classify the incoming op and precompute its bus lane enables and store data
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    fault     = 1'b0;
    acc_be    = 4'b1111;
    acc_wdata = wdata;

    if (is_load == is_store) fault = 1'b1;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) fault = 1'b1;
    if (is_store && funct3[2]) fault = 1'b1;
    if (funct3[1:0] == 2'b01 && addr[0]) fault = 1'b1;
    if (funct3 == F3_W && addr[1:0] != 2'b00) fault = 1'b1;

    case (funct3[1:0])
      2'b00: begin
        acc_be    = 4'b0001 << addr[1:0];
        acc_wdata = {4{wdata[7:0]}};
      end
      2'b01: begin
        acc_be    = 4'b0011 << addr[1:0];
        acc_wdata = {2{wdata[15:0]}};
      end
      default: begin
        acc_be    = 4'b1111;
        acc_wdata = wdata;
      end
    endcase
  end

  // Stall the core while a transaction is outstanding or an op is being accepted
  assign busy = (state == S_REQ) || (state == S_WAIT) || ((state == S_IDLE) && op_valid);

  // Transaction FSM with registered bus, pulse and result outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      is_load_q <= 1'b0;
      f3_q      <= 3'b000;
      off_q     <= 2'b00;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      done <= 1'b0;
      err  <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (op_valid) begin
            is_load_q <= is_load;
            f3_q      <= funct3;
            off_q     <= addr[1:0];
            if (fault) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state     <= S_REQ;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[D_WIDTH-1:2], 2'b00};
              mem_be    <= acc_be;
              mem_wdata <= is_store ? acc_wdata : '0;
            end
          end
        end

        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (!is_load_q) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (mem_rvalid) begin
              rdata <= load_ext(mem_rdata, off_q, f3_q);
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= '0;
            end
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            rdata <= load_ext(mem_rdata, off_q, f3_q);
            state <= S_DONE;
            done  <= 1'b1;
          end else if (cnt == TO_LAST) begin
            state <= S_ERR;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + TO_W'(1);
          end
        end

        S_DONE:  state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a table of single-cycle-grant transactions
// followed by hand-written multi-cycle sequences (grant stall, late rvalid,
// timeout, reset mid-transaction).
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  int n_vec  = 0;
  int n_miss = 0;

  lsu_ctrl #(.D_WIDTH(32), .TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr), .wdata(wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        exp_err;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_op();
    op_valid   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  task automatic present(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
    op_valid = 1'b1;
    is_load  = ld;
    is_store = st;
    funct3   = f3;
    addr     = a;
    wdata    = wd;
  endtask

  // One table row: grant (and rvalid for loads) available immediately
  task automatic run_vec(input vec_t v);
    present(v.ld, v.st, v.f3, v.a, v.wd);
    mem_gnt    = !v.exp_err;
    mem_rvalid = v.ld && !v.exp_err;
    mem_rdata  = v.rd;
    #1;
    check({v.name, " busy_accept"}, 32'(busy), 32'd1);
    tick();
    if (v.exp_err) begin
      check({v.name, " err"}, 32'(err), 32'd1);
      check({v.name, " no_req"}, 32'(mem_req), 32'd0);
      check({v.name, " busy_err"}, 32'(busy), 32'd0);
      drop_op();
      tick();
      check({v.name, " err_pulse"}, 32'(err), 32'd0);
    end else begin
      check({v.name, " req"}, 32'(mem_req), 32'd1);
      check({v.name, " addr"}, mem_addr, v.exp_addr);
      check({v.name, " be"}, 32'(mem_be), 32'(v.exp_be));
      check({v.name, " we"}, 32'(mem_we), 32'(v.exp_we));
      if (v.st) check({v.name, " wdata"}, mem_wdata, v.exp_wdata);
      tick();
      check({v.name, " done"}, 32'(done), 32'd1);
      check({v.name, " busy_done"}, 32'(busy), 32'd0);
      if (v.ld) check({v.name, " rdata"}, rdata, v.exp_rdata);
      drop_op();
      tick();
      check({v.name, " done_pulse"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int cycles;

    //                name      ld    st    f3      addr          wdata         mem_rdata     err   we    be       exp_addr      exp_wdata     exp_rdata
    vecs[0]  = '{"LB_103",  1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{"LBU_103", 1'b1, 1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 1'b0, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080};
    vecs[2]  = '{"LH_2",    1'b1, 1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1'b0, 1'b0, 4'b1100, 32'h0000_0000, 32'h0,        32'hFFFF_8001};
    vecs[3]  = '{"LW_10",   1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0,        32'h1234_5678, 1'b0, 1'b0, 4'b1111, 32'h0000_0010, 32'h0,        32'h1234_5678};
    vecs[4]  = '{"LB_1",    1'b1, 1'b0, 3'b000, 32'h0000_0001, 32'h0,        32'h1122_3344, 1'b0, 1'b0, 4'b0010, 32'h0000_0000, 32'h0,        32'h0000_0033};
    vecs[5]  = '{"SB_5",    1'b0, 1'b1, 3'b000, 32'h0000_0005, 32'h0000_00A5, 32'h0,        1'b0, 1'b1, 4'b0010, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0};
    vecs[6]  = '{"SW_8",    1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b1, 4'b1111, 32'h0000_0008, 32'hCAFE_F00D, 32'h0};
    vecs[7]  = '{"SH_22",   1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b1, 4'b1100, 32'h0000_0020, 32'hBEEF_BEEF, 32'h0};
    vecs[8]  = '{"LW_41",   1'b1, 1'b0, 3'b010, 32'h0000_0041, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[9]  = '{"LH_3",    1'b1, 1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[10] = '{"S_F3_100",1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[11] = '{"L_F3_011",1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[12] = '{"LD_AND_ST",1'b1,1'b1, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[13] = '{"NO_KIND", 1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};
    vecs[14] = '{"SH_1",    1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0,        32'h0,        1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0};

    rst = 1'b0;
    drop_op();
    funct3    = 3'b000;
    addr      = '0;
    wdata     = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_req", 32'(mem_req), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst err", 32'(err), 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst mem_be", 32'(mem_be), 32'd0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // SH with grant held off for two cycles: request must stay stable
    present(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'hDEAD_BEEF);
    tick();
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("shwait req c%0d", c), 32'(mem_req), 32'd1);
      check($sformatf("shwait we c%0d", c), 32'(mem_we), 32'd1);
      check($sformatf("shwait be c%0d", c), 32'(mem_be), 32'b1100);
      check($sformatf("shwait wdata c%0d", c), mem_wdata, 32'hBEEF_BEEF);
      check($sformatf("shwait addr c%0d", c), mem_addr, 32'h0000_0020);
      check($sformatf("shwait done c%0d", c), 32'(done), 32'd0);
      if (c == 3) mem_gnt = 1'b1;
      tick();
    end
    check("shwait done", 32'(done), 32'd1);
    check("shwait req_drop", 32'(mem_req), 32'd0);
    drop_op();
    tick();

    // LHU with rvalid three cycles after grant
    present(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0);
    mem_gnt = 1'b1;
    tick();
    check("lhu req", 32'(mem_req), 32'd1);
    check("lhu be", 32'(mem_be), 32'b1100);
    check("lhu we", 32'(mem_we), 32'd0);
    tick();
    mem_gnt = 1'b0;
    check("lhu wait_noreq", 32'(mem_req), 32'd0);
    check("lhu busy w1", 32'(busy), 32'd1);
    tick();
    check("lhu busy w2", 32'(busy), 32'd1);
    check("lhu done w2", 32'(done), 32'd0);
    tick();
    check("lhu busy w3", 32'(busy), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hABCD_0000;
    tick();
    check("lhu done", 32'(done), 32'd1);
    check("lhu rdata", rdata, 32'h0000_ABCD);
    check("lhu busy_done", 32'(busy), 32'd0);
    drop_op();
    tick();

    // Load whose data never arrives: err 16 cycles after entering WAIT
    present(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    cycles = 0;
    while (!err && cycles < 40) begin
      tick();
      cycles++;
    end
    check("timeout cycles", 32'(cycles), 32'd16);
    check("timeout err", 32'(err), 32'd1);
    check("timeout rdata_kept", rdata, 32'h0000_ABCD);
    check("timeout busy", 32'(busy), 32'd0);
    drop_op();
    tick();
    check("timeout err_pulse", 32'(err), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    check("late rvalid done", 32'(done), 32'd0);
    check("late rvalid rdata", rdata, 32'h0000_ABCD);
    check("late rvalid busy", 32'(busy), 32'd0);
    mem_rvalid = 1'b0;

    // Reset while waiting for data, then a clean SW
    present(1'b1, 1'b0, 3'b010, 32'h0000_0000, 32'h0);
    mem_gnt = 1'b1;
    tick();
    tick();
    mem_gnt = 1'b0;
    check("pre_rst busy", 32'(busy), 32'd1);
    rst = 1'b0;
    drop_op();
    tick();
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst mem_req", 32'(mem_req), 32'd0);
    check("midrst mem_we", 32'(mem_we), 32'd0);
    check("midrst mem_addr", mem_addr, 32'd0);
    check("midrst mem_be", 32'(mem_be), 32'd0);
    check("midrst mem_wdata", mem_wdata, 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst err", 32'(err), 32'd0);
    check("midrst rdata", rdata, 32'd0);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    check("postrst rvalid done", 32'(done), 32'd0);
    check("postrst rvalid rdata", rdata, 32'd0);
    mem_rvalid = 1'b0;
    present(1'b0, 1'b1, 3'b010, 32'h0000_0008, 32'h0102_0304);
    mem_gnt = 1'b1;
    tick();
    check("postrst sw req", 32'(mem_req), 32'd1);
    check("postrst sw we", 32'(mem_we), 32'd1);
    check("postrst sw be", 32'(mem_be), 32'b1111);
    check("postrst sw addr", mem_addr, 32'h0000_0008);
    check("postrst sw wdata", mem_wdata, 32'h0102_0304);
    tick();
    check("postrst sw done", 32'(done), 32'd1);
    drop_op();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and the second register operand as store data.
- Runs a req/gnt/rvalid transaction on the data-memory bus, then returns sign- or zero-extended load data to writeback.
- Multi-cycle: the core holds the instruction stalled while busy is high.

Parameters:
- D_WIDTH, 32, data/address width; only 32 is supported (4 byte lanes).
- TIMEOUT, 16, maximum cycles spent in WAIT before the load is aborted with err.
- TO_W, 5, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- op_valid  in  1  memory instruction present; held with its operands until done or err.
- is_load  in  1  load instruction.
- is_store  in  1  store instruction.
- funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  D_WIDTH  effective address (ALU output).
- wdata  in  D_WIDTH  store data (rs2).
- mem_req  out  1  bus request.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  D_WIDTH  word-aligned address, {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  D_WIDTH  lane-replicated store data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  D_WIDTH  read data word.
- busy  out  1  stall to core.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle fault pulse.
- rdata  out  D_WIDTH  extended load data; valid with done and held until the next accepted op.

Behaviour:
- Reset (rst=0 at a clock edge):
  - State becomes IDLE; timeout counter cleared.
  - All outputs 0 after the edge, including mem_req, mem_we, mem_addr, mem_be, mem_wdata, busy, done, err, rdata.
  - Applies mid-transaction: an outstanding request is dropped, and a later mem_rvalid/mem_gnt seen in IDLE is ignored.
- States: IDLE, REQ, WAIT, DONE, ERR.
- IDLE: when op_valid=1, the op, addr, wdata and funct3 are latched into registers.
  - Go to ERR if any of:
    - is_load==is_store;
    - funct3 illegal (store with 1xx, or any 011/110/111);
    - H/HU with addr[0]=1;
    - W with addr[1:0]!=0.
  - Otherwise go to REQ.
  - No bus activity occurs for faulting ops.
- REQ: mem_req=1; mem_we, mem_addr, mem_be, mem_wdata driven from registers and held stable until mem_gnt.
  - Store + gnt: go to DONE.
  - Load + gnt + rvalid in the same cycle: capture data, go to DONE.
  - Load + gnt without rvalid: go to WAIT, counter cleared.
- WAIT: mem_req=0; counter increments each cycle.
  - mem_rvalid: capture data, go to DONE.
  - Counter reaching TIMEOUT-1 without rvalid: go to ERR.
  - rvalid takes priority over timeout in the same cycle.
- DONE: done=1 for one cycle, then IDLE. op_valid is ignored here, giving a one-cycle bubble before the next op is accepted.
- ERR: err=1 for one cycle, rdata unchanged, then IDLE.
- busy = 1 in REQ and WAIT, plus combinationally in IDLE when op_valid=1; 0 in DONE and ERR.
- Stores, with o=addr[1:0]:
  - SB: be=4'b0001<<o, wdata={4{wdata[7:0]}}.
  - SH: be=4'b0011<<o, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata unchanged.
- Loads:
  - Shift s = mem_rdata >> (8*o).
  - B: sign-extend s[7:0]; BU: zero-extend s[7:0].
  - H: sign-extend s[15:0]; HU: zero-extend s[15:0].
  - W: mem_rdata unchanged.
  - Loads drive mem_be per size as for stores and mem_we=0.
- No pipelining: at most one outstanding transaction.

Test Plan:
- LB, addr=0x103, mem_rdata=0x80FF1234, gnt+rvalid same cycle → mem_addr=0x100, mem_be=1000, done one cycle later, rdata=0xFFFFFF80; LBU same → 0x00000080.
- SH, addr=0x22, wdata=0xDEADBEEF, gnt held low 2 cycles → mem_req stable 3 cycles, mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_addr=0x20, then done.
- LW, addr=0x41 → err pulse one cycle after acceptance, mem_req never asserted, busy low in the ERR cycle.
- LHU, addr=0x2, gnt then rvalid 3 cycles later with rdata=0xABCD0000 → rdata=0x0000ABCD, busy high until done.
- Load granted, rvalid never arrives (TIMEOUT=16) → err exactly 16 cycles after entering WAIT; a late rvalid arriving in IDLE is ignored.
- rst=0 while in WAIT → next cycle state IDLE with all outputs 0; a subsequent SW, addr=0x8, completes normally.
